yolo_max_pool_layer_sched: RTL and testbench
============================================

# yolo_max_pool_layer_sched

Layer scheduler for the `yolo_max_pool_top` HLS kernel. It holds a small per-layer configuration table and launches the kernel once per max-pool layer of the Tiny YOLO v3 network through the `ap_ctrl_hs` handshake, presenting each layer's geometry on the kernel's scalar inputs. It also runs a stream-activity watchdog, so a stalled `inStream`/`outStream` raises a sticky error in hardware instead of hanging the layer sequence.

## Interface
- `MAX_LAYERS`, 6, number of config table entries.
- `DIM_W`, 9, width/height field width (up to 511).
- `CH_W`, 10, channel field width (up to 1023).
- `TIMEOUT_CYCLES`, 1000000, consecutive beat-free cycles that trigger the watchdog; must be ≥2.
- `TO_W`, 20, watchdog counter width; must satisfy 2^TO_W > `TIMEOUT_CYCLES`.
- `AW`, 3, table address / layer index width; must satisfy 2^AW ≥ `MAX_LAYERS`+1.
- `ap_clk  in  1  clock.` All logic is on the rising edge.
- `ap_rst_n  in  1  reset.` Synchronous, active-low.
- `cfg_we  in  1  write strobe for one table entry.`
- `cfg_addr  in  AW  entry index.` Writes with `cfg_addr` ≥ `MAX_LAYERS` are ignored.
- `cfg_wdata  in  1+CH_W+2*DIM_W  packed {stride, channels, height, width}.` stride: 0 = 1, 1 = 2.
- `cfg_num_layers  in  AW  number of layers to run.` Sampled at `start`; values above `MAX_LAYERS` are clamped to `MAX_LAYERS`.
- `start  in  1  begin a run.`
- `busy  out  1  run in progress.`
- `done  out  1  one-cycle pulse when the run completes.`
- `error  out  1  sticky watchdog error.`
- `err_layer  out  AW  layer index captured at error.`
- `layer_idx  out  AW  current layer.`
- `k_ap_start  out  1`, `k_ap_ready  in  1`, `k_ap_done  in  1`, `k_ap_idle  in  1`: kernel control.
- `k_width  out  DIM_W`, `k_height  out  DIM_W`, `k_channels  out  CH_W`, `k_stride  out  1`: kernel config.
- `in_beat  in  1  inStream TVALID&TREADY.`
- `out_beat  in  1  outStream TVALID&TREADY.`

## Operation
**States:** IDLE, LAUNCH, WAIT_DONE, NEXT, ERROR.

- **IDLE**
  - `busy`=0.
  - `start` with clamped count N > 0: latch N, set `layer_idx`=0, clear `error`, go to LAUNCH.
  - `start` with N = 0: pulse `done` only and stay in IDLE.
- **LAUNCH**
  - `k_ap_start`=1.
  - `k_*` config is registered from table[`layer_idx`] and is stable while in the state.
  - `k_ap_ready`=1 and `k_ap_done`=0: go to WAIT_DONE.
  - `k_ap_ready`=1 and `k_ap_done`=1 in the same cycle: go to NEXT.
- **WAIT_DONE**
  - `k_ap_start`=0.
  - `k_ap_done` goes to NEXT.
- **NEXT**
  - If `layer_idx` = N-1: go to IDLE with `done`=1 for one cycle.
  - Otherwise: increment `layer_idx` and go to LAUNCH.
- **ERROR**
  - `busy`=0, `error`=1, `k_ap_start`=0.
  - `start` is accepted only if `k_ap_idle`=1; it behaves as `start` from IDLE. Otherwise `start` is ignored.

**Watchdog**
- Counts only in LAUNCH and WAIT_DONE.
- Cleared on entry to LAUNCH and on any cycle where `in_beat|out_beat` = 1.
- When the count reaches `TIMEOUT_CYCLES`: go to ERROR, capture `err_layer`=`layer_idx`.
- If `k_ap_done` arrives in the same cycle the count reaches the limit, `k_ap_done` wins.

**Table**
- Writes are accepted only when `busy`=0.
- The table is not cleared by a completed run.
- `k_*` config outputs hold their last values in IDLE and ERROR.

## Timing
**Reset values:** all outputs 0, state IDLE, counter 0, all table entries 0.

**Reset mid-run:** all outputs return to 0 on the next edge. The kernel is not aborted; the reset source owns kernel recovery.

**Cycle latencies:**
- `start` at cycle t (N > 0): `busy`=1, `k_ap_start`=1 and valid `k_*` config from t+1.
- `start` at t with N = 0: `done`=1 at t+1 only.
- `k_ap_ready` at r: `k_ap_start`=0 from r+1. `k_ap_start` never deasserts before `k_ap_ready` is seen.
- `k_ap_done` at d: state is NEXT at d+1. At d+2 either `k_ap_start`=1 with the next layer's config, or `done`=1 with `busy`=0.
- Last `k_ap_beat` (a `in_beat|out_beat` cycle) at b with no further activity: watchdog count reaches `TIMEOUT_CYCLES` at b+`TIMEOUT_CYCLES`; `error`=1 at b+`TIMEOUT_CYCLES`+1.

**Other rules:**
- `done` and `error` are never high in the same cycle.
- `start` while `busy`=1 is ignored.

## Test plan
1. **Reset values.** Hold `ap_rst_n`=0 for 3 cycles with random inputs → every output is 0; the table reads back as zeros (visible on `k_*` after a later run).
2. **Three-layer run.**
   - Stimulus: table = {416,416,16,s2}, {208,208,32,s2}, {13,13,512,s1}; N = 3; kernel model raises ready 1 cycle after start, done 40 cycles later, beats every cycle.
   - Required: exactly three `k_ap_start` handshakes with matching config; `layer_idx` sequence 0, 1, 2; one `done` pulse exactly 2 cycles after the third `k_ap_done`.
3. **Zero layers.** N = 0 → `done` at t+1; `k_ap_start` never rises; `busy` stays 0.
4. **Watchdog trip and clear.**
   - Stimulus: `TIMEOUT_CYCLES`=16; kernel model stops beats in layer 1; a single beat after 15 idle cycles restarts the count.
   - Required: `error`=1 and `err_layer`=1 at 17 cycles after the last beat.
   - Recovery: `start` with `k_ap_idle`=0 is ignored; `start` with `k_ap_idle`=1 restarts at layer 0 and clears `error`.
5. **Ready and done together.** Kernel raises `k_ap_ready` and `k_ap_done` in the same cycle → state skips WAIT_DONE; next `k_ap_start` follows 2 cycles later.
6. **Writes and start while busy.** `cfg_we` to entry 2 during a run, then a second run → layer 2 uses the original value; a `start` pulse mid-run has no effect.

Source files
------------

// File: rtl/yolo_max_pool_layer_sched.sv
// Layer scheduler for yolo_max_pool_top: config table, ap_ctrl_hs
// launch sequencing and a stream-activity watchdog.
module yolo_max_pool_layer_sched #(
  parameter int MAX_LAYERS     = 6,
  parameter int DIM_W          = 9,
  parameter int CH_W           = 10,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TO_W           = 20,
  parameter int AW             = 3
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      cfg_we,
  input  logic [AW-1:0]             cfg_addr,
  input  logic [CH_W+2*DIM_W:0]     cfg_wdata,
  input  logic [AW-1:0]             cfg_num_layers,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [AW-1:0]             err_layer,
  output logic [AW-1:0]             layer_idx,
  output logic                      k_ap_start,
  input  logic                      k_ap_ready,
  input  logic                      k_ap_done,
  input  logic                      k_ap_idle,
  output logic [DIM_W-1:0]          k_width,
  output logic [DIM_W-1:0]          k_height,
  output logic [CH_W-1:0]           k_channels,
  output logic                      k_stride,
  input  logic                      in_beat,
  input  logic                      out_beat
);

  localparam int CFG_W = 1 + CH_W + 2 * DIM_W;
  localparam logic [AW-1:0] MAX_L = AW'(MAX_LAYERS);
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_NEXT,
    S_ERR
  } state_t;

  state_t            state;
  logic [CFG_W-1:0]  tbl [MAX_LAYERS];
  logic [AW-1:0]     num_q;
  logic [TO_W-1:0]   wd_cnt;
  logic [TO_W-1:0]   wd_eff;
  logic              wd_hit;
  logic [AW-1:0]     n_clamp;
  logic [AW-1:0]     idx_nxt;
  logic [CFG_W-1:0]  cfg_nxt;

  // Watchdog view of this cycle, clamped count, next-layer lookup
  always_comb begin
    wd_eff  = (in_beat | out_beat) ? '0 : wd_cnt;
    wd_hit  = (wd_eff == TO_LIM);
    n_clamp = (cfg_num_layers > MAX_L) ? MAX_L : cfg_num_layers;
    idx_nxt = layer_idx + 1'b1;
    cfg_nxt = (idx_nxt < MAX_L) ? tbl[idx_nxt] : '0;
  end

  // Config table: writable only while no run is in progress
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      for (int i = 0; i < MAX_LAYERS; i++) tbl[i] <= '0;
    end else if (cfg_we && !busy && (cfg_addr < MAX_L)) begin
      tbl[cfg_addr] <= cfg_wdata;
    end
  end

  // Run sequencer with registered control/config outputs
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_layer  <= '0;
      layer_idx  <= '0;
      k_ap_start <= 1'b0;
      num_q      <= '0;
      wd_cnt     <= '0;
      {k_stride, k_channels, k_height, k_width} <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_ERR: begin
          if (start && (state == S_IDLE || k_ap_idle)) begin
            error <= 1'b0;
            if (n_clamp == '0) begin
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              num_q      <= n_clamp;
              layer_idx  <= '0;
              busy       <= 1'b1;
              k_ap_start <= 1'b1;
              wd_cnt     <= '0;
              {k_stride, k_channels, k_height, k_width} <= tbl[0];
              state      <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          if (k_ap_ready && k_ap_done) begin
            k_ap_start <= 1'b0;
            state      <= S_NEXT;
          end else if (wd_hit) begin
            k_ap_start <= 1'b0;
            busy       <= 1'b0;
            error      <= 1'b1;
            err_layer  <= layer_idx;
            state      <= S_ERR;
          end else begin
            wd_cnt <= wd_eff + 1'b1;
            if (k_ap_ready) begin
              k_ap_start <= 1'b0;
              state      <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (k_ap_done) begin
            state <= S_NEXT;
          end else if (wd_hit) begin
            busy      <= 1'b0;
            error     <= 1'b1;
            err_layer <= layer_idx;
            state     <= S_ERR;
          end else begin
            wd_cnt <= wd_eff + 1'b1;
          end
        end
        S_NEXT: begin
          if (layer_idx == num_q - 1'b1) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            layer_idx  <= idx_nxt;
            k_ap_start <= 1'b1;
            wd_cnt     <= '0;
            {k_stride, k_channels, k_height, k_width} <= cfg_nxt;
            state      <= S_LAUNCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_yolo_max_pool_layer_sched.sv
// Directed bench for yolo_max_pool_layer_sched: table runs, zero/clamped
// counts, ready+done merge, busy-time writes, watchdog trip and recovery.
module tb_yolo_max_pool_layer_sched;

  logic        clk = 1'b0;
  logic        ap_rst_n;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [28:0] cfg_wdata;
  logic [2:0]  cfg_num_layers;
  logic        start;
  logic        busy, done, error;
  logic [2:0]  err_layer, layer_idx;
  logic        k_ap_start, k_ap_ready, k_ap_done, k_ap_idle;
  logic [8:0]  k_width, k_height;
  logic [9:0]  k_channels;
  logic        k_stride;
  logic        in_beat, out_beat;

  int errors = 0;
  int checks = 0;
  int hs_cnt = 0;
  int done_cnt = 0;

  yolo_max_pool_layer_sched #(
    .TIMEOUT_CYCLES(16),
    .TO_W(5)
  ) dut (
    .ap_clk(clk), .ap_rst_n(ap_rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_num_layers(cfg_num_layers), .start(start),
    .busy(busy), .done(done), .error(error),
    .err_layer(err_layer), .layer_idx(layer_idx),
    .k_ap_start(k_ap_start), .k_ap_ready(k_ap_ready),
    .k_ap_done(k_ap_done), .k_ap_idle(k_ap_idle),
    .k_width(k_width), .k_height(k_height),
    .k_channels(k_channels), .k_stride(k_stride),
    .in_beat(in_beat), .out_beat(out_beat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (k_ap_start && k_ap_ready) hs_cnt++;
    if (done) done_cnt++;
  end

  typedef struct {
    logic [8:0] w;
    logic [8:0] h;
    logic [9:0] c;
    logic       s;
  } lay_t;

  typedef struct {
    logic [2:0] n;
    int         layers;
  } run_t;

  lay_t lay [3];
  run_t rv [3];

  function automatic logic [28:0] pk(input lay_t v);
    return {v.s, v.c, v.h, v.w};
  endfunction

  function automatic logic [28:0] kcfg();
    return {k_stride, k_channels, k_height, k_width};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; cfg_num_layers = 0;
    start = 0; k_ap_ready = 0; k_ap_done = 0; k_ap_idle = 1;
    in_beat = 0; out_beat = 0;
  endtask

  initial begin
    lay[0] = '{w: 9'd416, h: 9'd416, c: 10'd16,  s: 1'b1};
    lay[1] = '{w: 9'd208, h: 9'd208, c: 10'd32,  s: 1'b1};
    lay[2] = '{w: 9'd13,  h: 9'd13,  c: 10'd512, s: 1'b0};
    rv[0] = '{n: 3'd0, layers: 0};
    rv[1] = '{n: 3'd2, layers: 2};
    rv[2] = '{n: 3'd7, layers: 6};

    // reset with random inputs
    ap_rst_n = 0;
    for (int i = 0; i < 3; i++) begin
      cfg_we = 1'($urandom); cfg_addr = 3'($urandom);
      cfg_wdata = 29'($urandom); cfg_num_layers = 3'($urandom);
      start = 1'($urandom); k_ap_ready = 1'($urandom);
      k_ap_done = 1'($urandom); k_ap_idle = 1'($urandom);
      in_beat = 1'($urandom); out_beat = 1'($urandom);
      tick();
    end
    chk("rst_ctrl", {busy, done, error, k_ap_start}, 4'b0);
    chk("rst_idx", {err_layer, layer_idx}, 6'b0);
    chk("rst_cfg", kcfg(), 29'b0);
    idle_in();
    ap_rst_n = 1;
    tick();

    // zero table, N=2, ready+done merged each layer
    cfg_num_layers = 2; start = 1; tick(); start = 0;
    for (int i = 0; i < 2; i++) begin
      chk("z_kst", k_ap_start, 1);
      chk("z_idx", layer_idx, i);
      chk("z_cfg", kcfg(), 29'b0);
      k_ap_ready = 1; k_ap_done = 1; tick();
      k_ap_ready = 0; k_ap_done = 0;
      chk("z_next_kst", {busy, k_ap_start}, 2'b10);
      tick();
    end
    chk("z_done", {done, busy}, 2'b10);

    // table load, including an out-of-range address
    for (int i = 0; i < 3; i++) begin
      cfg_we = 1; cfg_addr = 3'(i); cfg_wdata = pk(lay[i]); tick();
    end
    cfg_addr = 3'd6; cfg_wdata = 29'h1FFFFFFF; tick();
    cfg_we = 0;

    // three-layer run with a 40-cycle kernel and steady beats
    hs_cnt = 0; done_cnt = 0;
    cfg_num_layers = 3; start = 1; tick(); start = 0;
    in_beat = 1; out_beat = 1;
    for (int i = 0; i < 3; i++) begin
      chk("r3_kst", {busy, k_ap_start}, 2'b11);
      chk("r3_idx", layer_idx, i);
      chk("r3_cfg", kcfg(), pk(lay[i]));
      tick();
      chk("r3_hold", k_ap_start, 1);
      k_ap_ready = 1; tick(); k_ap_ready = 0;
      chk("r3_drop", k_ap_start, 0);
      for (int j = 0; j < 39; j++) begin
        if (i == 0 && j == 5) begin
          start = 1; cfg_num_layers = 1;
          cfg_we = 1; cfg_addr = 2; cfg_wdata = 29'h0ABCDEF;
        end
        tick();
        start = 0; cfg_we = 0; cfg_num_layers = 3;
      end
      k_ap_done = 1; tick(); k_ap_done = 0;
      chk("r3_next", {busy, k_ap_start, done}, 3'b100);
      tick();
    end
    chk("r3_done", {done, busy}, 2'b10);
    tick();
    chk("r3_done_pulse", done, 0);
    chk("r3_hs", hs_cnt, 3);
    chk("r3_done_cnt", done_cnt, 1);
    in_beat = 0; out_beat = 0;

    // table-driven: zero count, plain run, clamped count
    for (int v = 0; v < 3; v++) begin
      cfg_num_layers = rv[v].n; start = 1; tick(); start = 0;
      for (int i = 0; i < rv[v].layers; i++) begin
        chk("tv_kst", {busy, k_ap_start}, 2'b11);
        chk("tv_idx", layer_idx, i);
        chk("tv_cfg", kcfg(), (i < 3) ? pk(lay[i]) : 29'b0);
        k_ap_ready = 1; k_ap_done = 1; tick();
        k_ap_ready = 0; k_ap_done = 0;
        chk("tv_next", {busy, k_ap_start}, 2'b10);
        tick();
      end
      chk("tv_done", {done, busy, k_ap_start}, 3'b100);
      tick();
    end

    // watchdog: restart by a beat, then trip in layer 1
    cfg_num_layers = 2; start = 1; tick(); start = 0;
    k_ap_ready = 1; k_ap_done = 1; tick();
    k_ap_ready = 0; k_ap_done = 0; tick();
    chk("wd_l1", {k_ap_start, layer_idx}, {1'b1, 3'd1});
    k_ap_ready = 1; in_beat = 1; tick();
    k_ap_ready = 0; in_beat = 0;
    repeat (15) tick();
    out_beat = 1; tick(); out_beat = 0;
    chk("wd_restart", error, 0);
    repeat (15) tick();
    chk("wd_before", {error, busy}, 2'b01);
    tick();
    chk("wd_trip", {error, busy, k_ap_start, done}, 4'b1000);
    chk("wd_err_layer", err_layer, 1);

    // recovery gated by k_ap_idle
    k_ap_idle = 0; cfg_num_layers = 2; start = 1; tick();
    chk("rec_ignored", {error, busy, k_ap_start}, 3'b100);
    k_ap_idle = 1; tick(); start = 0;
    chk("rec_start", {error, busy, k_ap_start}, 3'b011);
    chk("rec_idx", layer_idx, 0);
    chk("rec_cfg", kcfg(), pk(lay[0]));

    // done arriving on the limit cycle beats the watchdog
    k_ap_ready = 1; in_beat = 1; tick();
    k_ap_ready = 0; in_beat = 0;
    repeat (15) tick();
    k_ap_done = 1; tick(); k_ap_done = 0;
    chk("dw_next", {error, busy, k_ap_start}, 3'b010);
    tick();
    chk("dw_l1", {k_ap_start, layer_idx}, {1'b1, 3'd1});
    k_ap_ready = 1; k_ap_done = 1; tick();
    k_ap_ready = 0; k_ap_done = 0; tick();
    chk("dw_done", {done, error, busy}, 3'b100);

    // reset in the middle of a run
    cfg_num_layers = 3; start = 1; tick(); start = 0;
    chk("mr_run", k_ap_start, 1);
    ap_rst_n = 0; tick(); ap_rst_n = 1;
    chk("mr_ctrl", {busy, done, error, k_ap_start, layer_idx}, 7'b0);
    chk("mr_cfg", kcfg(), 29'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
